// File: rtl/vga_text_writer_if.sv
// Byte-stream and VRAM-write bundle for vga_text_writer.
// The master side feeds characters/clears and watches the VRAM port and cursor;
// the slave side is the text writer itself.
interface vga_text_writer_if #(
    parameter int AW = 11
);
    logic          char_valid;
    logic [7:0]    char_data;
    logic          char_ready;
    logic [7:0]    attr;
    logic          clear_req;
    logic [AW-1:0] vram_waddr;
    logic [15:0]   vram_wdata;
    logic          vram_we;
    logic [5:0]    cursor_x;
    logic [4:0]    cursor_y;

    modport master (
        output char_valid, char_data, attr, clear_req,
        input  char_ready, vram_waddr, vram_wdata, vram_we, cursor_x, cursor_y
    );

    modport slave (
        input  char_valid, char_data, attr, clear_req,
        output char_ready, vram_waddr, vram_wdata, vram_we, cursor_x, cursor_y
    );
endinterface

// File: rtl/vga_text_writer.sv
// Character-stream front end for the 40x30 text display.
// Accepts bytes over valid/ready, keeps a cursor, interprets CR/LF/BS and
// drives the VRAM write port with {attr,char} cells, one cell per cycle.
// The screen is a circular buffer: a row advance wraps and blanks the new row.
module vga_text_writer #(
    parameter int         COLS  = 40,
    parameter int         ROWS  = 30,
    parameter int         AW    = 11,
    parameter logic [7:0] BLANK = 8'h20
) (
    input logic              clk,
    input logic              rst_n,
    vga_text_writer_if.slave bus
);

    localparam int            CELLS        = COLS * ROWS;
    localparam logic [AW-1:0] LAST_CELL    = AW'(CELLS - 1);
    localparam logic [AW-1:0] LAST_COL_CNT = AW'(COLS - 1);
    localparam logic [AW-1:0] ROW_STEP     = AW'(COLS);
    localparam logic [5:0]    LAST_X       = 6'(COLS - 1);
    localparam logic [4:0]    LAST_Y       = 5'(ROWS - 1);

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;

    typedef enum logic [1:0] {
        CLR_ALL,
        IDLE,
        CLR_ROW
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;      // position inside the running clear
    logic [AW-1:0] row_base_q, row_base_d;    // y * COLS, kept incrementally
    logic [5:0]    x_q, x_d;
    logic [4:0]    y_q, y_d;
    logic [7:0]    attr_q, attr_d;            // attribute used by clear engines
    logic          attr_load_q, attr_load_d;  // first clear after reset takes live attr
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [15:0]   wdata_q, wdata_d;

    logic          take_clear;
    logic          take_char;
    logic          row_advance;
    logic [7:0]    clr_attr;

    // The reset-time clear has no earlier clear_req to sample attr from, so
    // its first cell uses the live input and latches it for the rest.
    assign clr_attr = attr_load_q ? bus.attr : attr_q;

    // clear_req wins over a character offered in the same idle cycle.
    assign take_clear = (state_q == IDLE) && bus.clear_req;
    assign take_char  = (state_q == IDLE) && !bus.clear_req && bus.char_valid;

    // Next-state, cursor and VRAM-port values for the clears and the character handler.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path infers a latch.
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        row_base_d  = row_base_q;
        x_d         = x_q;
        y_d         = y_q;
        attr_d      = attr_q;
        attr_load_d = 1'b0;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        row_advance = 1'b0;

        unique case (state_q)
            CLR_ALL: begin
                we_d    = 1'b1;
                waddr_d = clr_cnt_q;
                wdata_d = {clr_attr, BLANK};
                attr_d  = clr_attr;
                if (clr_cnt_q == LAST_CELL) begin
                    clr_cnt_d  = '0;
                    x_d        = '0;
                    y_d        = '0;
                    row_base_d = '0;
                    state_d    = IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end

            CLR_ROW: begin
                we_d    = 1'b1;
                waddr_d = row_base_q + clr_cnt_q;
                wdata_d = {attr_q, BLANK};
                if (clr_cnt_q == LAST_COL_CNT) begin
                    clr_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end

            IDLE: begin
                if (take_clear) begin
                    attr_d    = bus.attr;
                    clr_cnt_d = '0;
                    state_d   = CLR_ALL;
                end else if (take_char) begin
                    case (bus.char_data)
                        CH_CR: begin
                            x_d = '0;
                        end

                        CH_LF: begin
                            x_d         = '0;
                            row_advance = 1'b1;
                        end

                        CH_BS: begin
                            // Backspace at column 0 does nothing at all.
                            if (x_q != '0) begin
                                x_d     = x_q - 1'b1;
                                we_d    = 1'b1;
                                waddr_d = row_base_q + AW'(x_q - 1'b1);
                                wdata_d = {bus.attr, BLANK};
                            end
                        end

                        default: begin
                            we_d    = 1'b1;
                            waddr_d = row_base_q + AW'(x_q);
                            wdata_d = {bus.attr, bus.char_data};
                            if (x_q == LAST_X) begin
                                x_d         = '0;
                                row_advance = 1'b1;
                            end else begin
                                x_d = x_q + 1'b1;
                            end
                        end
                    endcase

                    // A new row is always blanked before the next character lands.
                    if (row_advance) begin
                        attr_d    = bus.attr;
                        clr_cnt_d = '0;
                        state_d   = CLR_ROW;
                        if (y_q == LAST_Y) begin
                            y_d        = '0;
                            row_base_d = '0;
                        end else begin
                            y_d        = y_q + 1'b1;
                            row_base_d = row_base_q + ROW_STEP;
                        end
                    end
                end
            end

            default: begin
                clr_cnt_d = '0;
                state_d   = CLR_ALL;
            end
        endcase
    end

    // State, cursor and output registers; reset restarts the full-screen clear from cell 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CLR_ALL;
            clr_cnt_q   <= '0;
            row_base_q  <= '0;
            x_q         <= '0;
            y_q         <= '0;
            attr_q      <= '0;
            attr_load_q <= 1'b1;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            row_base_q  <= row_base_d;
            x_q         <= x_d;
            y_q         <= y_d;
            attr_q      <= attr_d;
            attr_load_q <= attr_load_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign bus.char_ready = (state_q == IDLE);
    assign bus.vram_we    = we_q;
    assign bus.vram_waddr = waddr_q;
    assign bus.vram_wdata = wdata_q;
    assign bus.cursor_x   = x_q;
    assign bus.cursor_y   = y_q;

endmodule

// File: tb/tb_vga_text_writer.sv
// Self-checking bench for vga_text_writer: a table of single-character vectors,
// hand-written multi-cycle sequences and a randomized phase, all scored against
// a screen-level model (array of cells plus a cursor).
module tb_vga_text_writer;

    localparam int COLS  = 40;
    localparam int ROWS  = 30;
    localparam int AW    = 11;
    localparam int CELLS = COLS * ROWS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    vga_text_writer_if #(.AW(AW)) bus ();

    vga_text_writer #(
        .COLS (COLS),
        .ROWS (ROWS),
        .AW   (AW),
        .BLANK(8'h20)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [15:0]   data;
        int            cyc;
    } wr_t;

    typedef struct {
        logic [7:0]  c;
        logic [7:0]  a;
        logic        exp_we;
        int          exp_addr;
        logic [15:0] exp_data;
        int          exp_x;
        int          exp_y;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    wr_t         act_q[$];
    wr_t         exp_q[$];
    logic [15:0] dut_mem[CELLS];
    logic [15:0] mmem[CELLS];
    int          mx = 0;
    int          my = 0;
    int          exp_busy = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every VRAM write the DUT makes.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.vram_we === 1'b1) begin
            act_q.push_back('{bus.vram_waddr, bus.vram_wdata, cyc});
            dut_mem[bus.vram_waddr] = bus.vram_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- screen-level reference model ----------------
    task automatic m_write(input int addr, input logic [15:0] d);
        mmem[addr] = d;
        exp_q.push_back('{AW'(addr), d, 0});
    endtask

    task automatic m_newline(input logic [7:0] a);
        my = (my + 1) % ROWS;
        for (int c = 0; c < COLS; c++) m_write(my * COLS + c, {a, 8'h20});
        exp_busy = COLS;
    endtask

    task automatic m_char(input logic [7:0] c, input logic [7:0] a);
        exp_busy = 0;
        if (c == 8'h0D) begin
            mx = 0;
        end else if (c == 8'h0A) begin
            mx = 0;
            m_newline(a);
        end else if (c == 8'h08) begin
            if (mx > 0) begin
                mx = mx - 1;
                m_write(my * COLS + mx, {a, 8'h20});
            end
        end else begin
            m_write(my * COLS + mx, {a, c});
            mx = mx + 1;
            if (mx == COLS) begin
                mx = 0;
                m_newline(a);
            end
        end
    endtask

    task automatic m_clear_all(input logic [7:0] a);
        for (int i = 0; i < CELLS; i++) m_write(i, {a, 8'h20});
        mx = 0;
        my = 0;
        exp_busy = CELLS;
    endtask

    // ---------------- bench helpers ----------------
    // Counts sample points (negedge+1) with char_ready low, bounded.
    task automatic wait_ready(input string name, output int lows);
        lows = 0;
        while (bus.char_ready !== 1'b1 && lows < 3000) begin
            lows++;
            @(negedge clk);
            #1;
        end
        if (bus.char_ready !== 1'b1) check({name, " ready_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic compare_writes(input string name);
        int bad = 0;
        int gaps = 0;
        int n;
        check({name, " write_count"}, act_q.size(), exp_q.size());
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (act_q[i].addr !== exp_q[i].addr || act_q[i].data !== exp_q[i].data) begin
                if (bad == 0)
                    $display("  %s: write #%0d is addr %0d data %h, model has addr %0d data %h",
                             name, i, act_q[i].addr, act_q[i].data, exp_q[i].addr, exp_q[i].data);
                bad++;
            end
            if (i > 0 && act_q[i].cyc != act_q[i-1].cyc + 1) gaps++;
        end
        check({name, " write_content"}, bad, 0);
        check({name, " write_gaps"}, gaps, 0);
        act_q.delete();
        exp_q.delete();
    endtask

    // Offers one character (valid held until accepted), captures the outputs one
    // cycle after acceptance, then scores the whole operation against the model.
    task automatic do_char(input logic [7:0] c, input logic [7:0] a, input string name,
                           output logic o_we, output logic [AW-1:0] o_addr,
                           output logic [15:0] o_data, output int o_x, output int o_y);
        int lows;
        bus.char_data  = c;
        bus.attr       = a;
        bus.char_valid = 1'b1;
        wait_ready(name, lows);
        @(posedge clk);
        #1;
        bus.char_valid = 1'b0;
        o_we   = bus.vram_we;
        o_addr = bus.vram_waddr;
        o_data = bus.vram_wdata;
        o_x    = int'(bus.cursor_x);
        o_y    = int'(bus.cursor_y);
        m_char(c, a);
        @(negedge clk);
        #1;
        wait_ready(name, lows);
        check({name, " ready_low_cycles"}, lows, exp_busy);
        compare_writes(name);
        check({name, " cursor_x"}, bus.cursor_x, mx);
        check({name, " cursor_y"}, bus.cursor_y, my);
    endtask

    task automatic do_clear(input logic [7:0] a, input logic with_char, input string name);
        int lows;
        bus.attr       = a;
        bus.clear_req  = 1'b1;
        bus.char_valid = with_char;
        bus.char_data  = 8'h51;
        wait_ready(name, lows);
        @(posedge clk);
        #1;
        bus.clear_req  = 1'b0;
        bus.char_valid = 1'b0;
        check({name, " ready_after_req"}, bus.char_ready, 1'b0);
        check({name, " no_write_on_req"}, bus.vram_we, 1'b0);
        m_clear_all(a);
        @(negedge clk);
        #1;
        wait_ready(name, lows);
        check({name, " ready_low_cycles"}, lows, exp_busy);
        compare_writes(name);
        check({name, " cursor_x"}, bus.cursor_x, 0);
        check({name, " cursor_y"}, bus.cursor_y, 0);
    endtask

    initial begin
        vec_t          vecs[7];
        logic          w;
        logic [AW-1:0] ad;
        logic [15:0]   d;
        int            xx, yy, lows, diffs;
        logic [7:0]    rc, ra;

        vecs[0] = '{8'h41, 8'h1C, 1'b1, 0, 16'h1C41, 1, 0};
        vecs[1] = '{8'h42, 8'h07, 1'b1, 1, 16'h0742, 2, 0};
        vecs[2] = '{8'h0D, 8'h07, 1'b0, 0, 16'h0000, 0, 0};
        vecs[3] = '{8'h08, 8'h07, 1'b0, 0, 16'h0000, 0, 0};
        vecs[4] = '{8'h78, 8'h2F, 1'b1, 0, 16'h2F78, 1, 0};
        vecs[5] = '{8'h79, 8'h30, 1'b1, 1, 16'h3079, 2, 0};
        vecs[6] = '{8'h08, 8'h4E, 1'b1, 1, 16'h4E20, 1, 0};

        bus.char_valid = 1'b0;
        bus.char_data  = 8'h00;
        bus.clear_req  = 1'b0;
        bus.attr       = 8'h07;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check("reset vram_we", bus.vram_we, 1'b0);
        check("reset vram_waddr", bus.vram_waddr, 0);
        check("reset vram_wdata", bus.vram_wdata, 16'h0000);
        check("reset char_ready", bus.char_ready, 1'b0);
        check("reset cursor_x", bus.cursor_x, 0);
        check("reset cursor_y", bus.cursor_y, 0);

        // Power-up clear with attr 07.
        rst_n = 1'b1;
        m_clear_all(8'h07);
        @(negedge clk);
        #1;
        wait_ready("powerup", lows);
        compare_writes("powerup");
        check("powerup char_ready", bus.char_ready, 1'b1);
        check("powerup cursor_x", bus.cursor_x, 0);
        check("powerup cursor_y", bus.cursor_y, 0);

        // Table of single-character vectors from (0,0).
        for (int i = 0; i < 7; i++) begin
            do_char(vecs[i].c, vecs[i].a, $sformatf("vec%0d", i), w, ad, d, xx, yy);
            check($sformatf("vec%0d we", i), w, vecs[i].exp_we);
            if (vecs[i].exp_we) begin
                check($sformatf("vec%0d addr", i), ad, vecs[i].exp_addr);
                check($sformatf("vec%0d data", i), d, vecs[i].exp_data);
            end
            check($sformatf("vec%0d next_x", i), xx, vecs[i].exp_x);
            check($sformatf("vec%0d next_y", i), yy, vecs[i].exp_y);
        end
        @(negedge clk);
        #1;
        check("idle vram_we", bus.vram_we, 1'b0);

        // clear_req and char_valid together: clear wins, char dropped.
        do_clear(8'h05, 1'b1, "clear_vs_char");

        // 41 printables from (0,0); the 41st is held valid through the row clear.
        for (int i = 0; i < 39; i++)
            do_char(8'h61 + 8'(i % 26), 8'h1C, "row_fill", w, ad, d, xx, yy);
        bus.char_data  = 8'h2A;
        bus.attr       = 8'h1C;
        bus.char_valid = 1'b1;
        wait_ready("wrap c40", lows);
        @(posedge clk);
        #1;
        bus.char_data = 8'h2B;
        m_char(8'h2A, 8'h1C);
        @(negedge clk);
        #1;
        wait_ready("wrap c41", lows);
        check("wrap held_valid_wait", lows, COLS);
        @(posedge clk);
        #1;
        bus.char_valid = 1'b0;
        check("wrap c41 we", bus.vram_we, 1'b1);
        check("wrap c41 addr", bus.vram_waddr, 40);
        check("wrap c41 data", bus.vram_wdata, 16'h1C2B);
        m_char(8'h2B, 8'h1C);
        @(negedge clk);
        #1;
        compare_writes("wrap");
        check("wrap cursor_x", bus.cursor_x, 1);
        check("wrap cursor_y", bus.cursor_y, 1);

        // Backspace at column 0 and at column 2 of row 3.
        do_char(8'h0A, 8'h07, "to_row2", w, ad, d, xx, yy);
        do_char(8'h0A, 8'h07, "to_row3", w, ad, d, xx, yy);
        do_char(8'h08, 8'h07, "bs_col0", w, ad, d, xx, yy);
        check("bs_col0 we", w, 1'b0);
        check("bs_col0 x", xx, 0);
        check("bs_col0 y", yy, 3);
        do_char(8'h70, 8'h07, "bs_prep", w, ad, d, xx, yy);
        do_char(8'h71, 8'h07, "bs_prep", w, ad, d, xx, yy);
        do_char(8'h08, 8'h12, "bs_col2", w, ad, d, xx, yy);
        check("bs_col2 we", w, 1'b1);
        check("bs_col2 addr", ad, 121);
        check("bs_col2 data", d, 16'h1220);
        check("bs_col2 x", xx, 1);
        check("bs_col2 y", yy, 3);

        // LF on the last row wraps to row 0 and blanks it.
        do_char(8'h0D, 8'h07, "cr", w, ad, d, xx, yy);
        while (my != ROWS - 1) do_char(8'h0A, 8'h07, "walk_down", w, ad, d, xx, yy);
        for (int i = 0; i < 5; i++) do_char(8'h30 + 8'(i), 8'h07, "row29", w, ad, d, xx, yy);
        check("row29 cursor_x", bus.cursor_x, 5);
        do_char(8'h0A, 8'h24, "lf_wrap", w, ad, d, xx, yy);
        check("lf_wrap we", w, 1'b0);
        check("lf_wrap y", yy, 0);

        // Reset in the middle of a full clear restarts it from cell 0.
        bus.attr      = 8'h6B;
        bus.clear_req = 1'b1;
        @(posedge clk);
        #1;
        bus.clear_req = 1'b0;
        repeat (100) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset vram_we", bus.vram_we, 1'b0);
        check("midreset vram_waddr", bus.vram_waddr, 0);
        check("midreset char_ready", bus.char_ready, 1'b0);
        act_q.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        #1;
        bus.attr = 8'h3A;
        rst_n    = 1'b1;
        m_clear_all(8'h3A);
        @(negedge clk);
        #1;
        wait_ready("restart", lows);
        compare_writes("restart");
        check("restart cursor_x", bus.cursor_x, 0);
        check("restart cursor_y", bus.cursor_y, 0);

        // Randomized stream against the screen model.
        for (int n = 0; n < 250; n++) begin
            int pick;
            pick = int'($urandom_range(0, 9));
            ra   = 8'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                do_clear(ra, 1'($urandom), "rnd_clear");
            end else begin
                if (pick == 0) rc = 8'h0D;
                else if (pick == 1) rc = 8'h0A;
                else if (pick <= 3) rc = 8'h08;
                else begin
                    rc = 8'($urandom);
                    while (rc == 8'h0A || rc == 8'h0D || rc == 8'h08) rc = 8'($urandom);
                end
                do_char(rc, ra, "rnd", w, ad, d, xx, yy);
            end
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                #1;
            end
        end

        // Whole-screen contents.
        diffs = 0;
        for (int i = 0; i < CELLS; i++) if (dut_mem[i] !== mmem[i]) diffs++;
        check("screen contents", diffs, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
